// File: rtl/breg_seq.sv
// ---------------------------------------------------------------------------
// breg_seq -- instruction sequencer for the 4x8-bit dual-read register bank.
//
// Accepts one 16-bit instruction per valid/ready handshake, reads two operands
// through the bank's combinational read ports, computes an 8-bit ALU result
// and writes it back through the bank's single active-low write port.
//
// Instruction fields: op[15:12] dst[11:10] src0[9:8] src1[1:0] imm[7:0]
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr[15:0]              instruction word
//   out_valid/out_ready      OUT result handshake, out_data[7:0] = src0
//   add_rd0/add_rd1, rd0/rd1 bank read addresses and returned data
//   add_wr, wr_data, wr_n    bank write address, data, active-low strobe
//   flag_z, flag_c           zero / carry flags
//   err                      sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module breg_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [1:0]  add_rd0,
    output logic [1:0]  add_rd1,
    input  logic [7:0]  rd0,
    input  logic [7:0]  rd1,
    output logic [1:0]  add_wr,
    output logic [7:0]  wr_data,
    output logic        wr_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EXEC, S_WRITE, S_OUTW
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;

    state_t      r_state, w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_dst;
    logic [7:0]  r_imm;
    logic [7:0]  r_opa, r_opb;
    logic [1:0]  r_add_rd0, r_add_rd1, r_add_wr;
    logic [7:0]  r_wr_data, r_out_data;
    logic        r_wr_n, r_out_valid;
    logic        r_z, r_c, r_err;

    // Bit 8 of the ALU result is the carry/borrow; each op sets it so that
    // flag_c can always be taken straight from bit 8 when w_upd_c is set.
    logic [8:0]  w_alu;
    logic        w_wr, w_upd_z, w_upd_c, w_illegal;

    // ---------------------------------------------------------------- ALU
    // NOTE: every output of a combinational block is defaulted first, so no
    // path through the case leaves a value held and no latch is inferred.
    always_comb begin
        w_alu     = 9'd0;
        w_wr      = 1'b0;
        w_upd_z   = 1'b0;
        w_upd_c   = 1'b0;
        w_illegal = 1'b0;
        case (r_op)
            OP_NOP: ;
            OP_LDI: begin w_alu = {1'b0, r_imm}; w_wr = 1'b1; w_upd_z = 1'b1; end
            OP_MOV: begin w_alu = {1'b0, r_opa}; w_wr = 1'b1; w_upd_z = 1'b1; end
            OP_ADD: begin
                w_alu = {1'b0, r_opa} + {1'b0, r_opb};
                w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1;
            end
            // Two's-complement subtract of zero-extended operands leaves the
            // borrow (src0 < src1) in bit 8.
            OP_SUB, OP_CMP: begin
                w_alu = {1'b0, r_opa} - {1'b0, r_opb};
                w_wr = (r_op == OP_SUB); w_upd_z = 1'b1; w_upd_c = 1'b1;
            end
            OP_AND: begin w_alu = {1'b0, r_opa & r_opb}; w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
            OP_OR:  begin w_alu = {1'b0, r_opa | r_opb}; w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
            OP_XOR: begin w_alu = {1'b0, r_opa ^ r_opb}; w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
            OP_SHL: begin w_alu = {r_opa, 1'b0}; w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
            // Shifted-out bit 0 goes to the carry position.
            OP_SHR: begin w_alu = {r_opa[0], 1'b0, r_opa[7:1]}; w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
            OP_OUT: ;
            default: w_illegal = 1'b1;
        endcase
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC: begin
                if (w_wr)                  w_next = S_WRITE;
                else if (r_op == OP_OUT)   w_next = S_OUTW;
                else                       w_next = S_IDLE;
            end
            S_WRITE: w_next = S_IDLE;
            S_OUTW:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NOP;
            r_dst       <= 2'd0;
            r_imm       <= 8'd0;
            r_opa       <= 8'd0;
            r_opb       <= 8'd0;
            r_add_rd0   <= 2'd0;
            r_add_rd1   <= 2'd0;
            r_add_wr    <= 2'd0;
            r_wr_data   <= 8'd0;
            r_out_data  <= 8'd0;
            r_wr_n      <= 1'b1;
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Strobes decoded from the next state so they come straight from
            // a flop and are active for exactly the WRITE / OUTW cycles.
            r_wr_n      <= (w_next != S_WRITE);
            r_out_valid <= (w_next == S_OUTW);
            case (r_state)
                S_IDLE: if (instr_valid) begin
                    r_op      <= instr[15:12];
                    r_dst     <= instr[11:10];
                    r_imm     <= instr[7:0];
                    r_add_rd0 <= instr[9:8];
                    r_add_rd1 <= instr[1:0];
                end
                S_READ: begin
                    r_opa <= rd0;
                    r_opb <= rd1;
                end
                S_EXEC: begin
                    if (w_wr) begin
                        r_add_wr  <= r_dst;
                        r_wr_data <= w_alu[7:0];
                    end
                    if (w_upd_z)         r_z        <= (w_alu[7:0] == 8'd0);
                    if (w_upd_c)         r_c        <= w_alu[8];
                    if (w_illegal)       r_err      <= 1'b1;
                    if (r_op == OP_OUT)  r_out_data <= r_opa;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign add_rd0     = r_add_rd0;
    assign add_rd1     = r_add_rd1;
    assign add_wr      = r_add_wr;
    assign wr_data     = r_wr_data;
    assign wr_n        = r_wr_n;
    assign flag_z      = r_z;
    assign flag_c      = r_c;
    assign err         = r_err;

endmodule

// File: tb/tb_breg_seq.sv
// ---------------------------------------------------------------------------
// tb_breg_seq -- self-checking bench for breg_seq.
// Hosts a behavioural 4x8 register bank, drives directed and random
// instructions, and compares against an architectural model of the ISA.
// ---------------------------------------------------------------------------
module tb_breg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  add_rd0, add_rd1, add_wr;
    logic [7:0]  rd0, rd1, wr_data;
    logic        wr_n, flag_z, flag_c, err;

    always #5 clk = ~clk;

    breg_seq dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .add_rd0(add_rd0), .add_rd1(add_rd1), .rd0(rd0), .rd1(rd1),
        .add_wr(add_wr), .wr_data(wr_data), .wr_n(wr_n),
        .flag_z(flag_z), .flag_c(flag_c), .err(err)
    );

    // Register bank the sequencer drives.
    logic [7:0] bank [4];
    assign rd0 = bank[add_rd0];
    assign rd1 = bank[add_rd1];
    always @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < 4; i++) bank[i] <= 8'd0;
        else if (!wr_n) bank[add_wr] <= wr_data;
    end

    // Architectural model state.
    int m_reg [4];
    int m_z, m_c, m_err;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ldi(input logic [1:0] d, input logic [7:0] imm);
        return {4'h1, d, 2'b00, imm};
    endfunction

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [1:0] d,
                                        input logic [1:0] s0, input logic [1:0] s1);
        return {op, d, s0, 6'b000000, s1};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_z = 0; m_c = 0; m_err = 0;
    endtask

    // Executes one instruction on the model; reports write, result and kind.
    task automatic model_step(input logic [15:0] ins, output bit wr, output int dst,
                              output int res, output bit is_out);
        int op, a, b, imm;
        op  = ins[15:12];
        a   = m_reg[ins[9:8]];
        b   = m_reg[ins[1:0]];
        imm = ins[7:0];
        dst = ins[11:10];
        wr = 0; is_out = 0; res = 0;
        case (op)
            0:  ;
            1:  begin res = imm; wr = 1; end
            2:  begin res = a; wr = 1; end
            3:  begin res = (a + b) % 256; m_c = (a + b > 255); wr = 1; end
            4:  begin res = (a - b + 256) % 256; m_c = (a < b); wr = 1; end
            5:  begin res = a & b; m_c = 0; wr = 1; end
            6:  begin res = a | b; m_c = 0; wr = 1; end
            7:  begin res = a ^ b; m_c = 0; wr = 1; end
            8:  begin res = (a * 2) % 256; m_c = (a >= 128); wr = 1; end
            9:  begin res = a / 2; m_c = a % 2; wr = 1; end
            10: begin res = (a - b + 256) % 256; m_c = (a < b); end
            11: begin res = a; is_out = 1; end
            default: m_err = 1;
        endcase
        if (op >= 1 && op <= 10) m_z = (res == 0);
        if (wr) m_reg[dst] = res;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  instr_ready, 1);
        check({tag, "_wr_n"},   wr_n, 1);
        check({tag, "_ovalid"}, out_valid, 0);
        check({tag, "_odata"},  out_data, 0);
        check({tag, "_rd0"},    add_rd0, 0);
        check({tag, "_rd1"},    add_rd1, 0);
        check({tag, "_wadr"},   add_wr, 0);
        check({tag, "_wdat"},   wr_data, 0);
        check({tag, "_z"},      flag_z, 0);
        check({tag, "_c"},      flag_c, 0);
        check({tag, "_err"},    err, 0);
    endtask

    // Issues one instruction, follows it to completion and checks the
    // write timing, OUT handshake, latency, flags and resulting bank state.
    task automatic run(input logic [15:0] ins, input int hold);
        bit wr, is_out, done;
        int dst, res, lat, k, wr_cnt, wr_at, ov_cnt;
        model_step(ins, wr, dst, res, is_out);
        lat = is_out ? 4 + hold : (wr ? 4 : 3);
        @(negedge clk);
        check("ready_idle", instr_ready, 1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        wr_cnt = 0; wr_at = 0; ov_cnt = 0; done = 0; k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            if (instr_ready) done = 1;
            else begin
                if (!wr_n) begin
                    wr_cnt++;
                    wr_at = k;
                    check("wr_addr", add_wr, 16'(dst));
                    check("wr_data", wr_data, 16'(res));
                end
                if (out_valid) begin
                    ov_cnt++;
                    check("out_data", out_data, 16'(res));
                    if (ov_cnt > hold) out_ready = 1'b1;
                end
            end
        end
        out_ready = 1'b0;
        check("no_timeout", done, 1);
        check("latency", 16'(k), 16'(lat));
        check("wr_count", 16'(wr_cnt), wr ? 16'd1 : 16'd0);
        if (wr) check("wr_cycle", 16'(wr_at), 16'd3);
        check("out_cycles", 16'(ov_cnt), is_out ? 16'(hold + 1) : 16'd0);
        check("idle_wr_n", wr_n, 1);
        check("idle_ovalid", out_valid, 0);
        check("flag_z", flag_z, 16'(m_z));
        check("flag_c", flag_c, 16'(m_c));
        check("err", err, 16'(m_err));
        for (int i = 0; i < 4; i++) check("bank", bank[i], 16'(m_reg[i]));
    endtask

    initial begin
        logic [15:0] ins;
        int op, k;
        rst = 1'b1;
        instr_valid = 1'b1;  // offered during reset: must not be captured
        instr = ldi(2'd3, 8'h77);
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        instr_valid = 1'b0;
        rst = 1'b0;

        // ADD wrapping to zero with carry.
        run(ldi(2'd0, 8'h5A), 0);
        run(ldi(2'd1, 8'hA6), 0);
        run(alu(4'h3, 2'd2, 2'd0, 2'd1), 0);
        check("add_r2", bank[2], 16'h00);
        check("add_z", flag_z, 1);
        check("add_c", flag_c, 1);

        // SUB with borrow, then CMP without write.
        run(ldi(2'd0, 8'h10), 0);
        run(ldi(2'd1, 8'h20), 0);
        run(alu(4'h4, 2'd3, 2'd0, 2'd1), 0);
        check("sub_r3", bank[3], 16'hF0);
        run(alu(4'hA, 2'd2, 2'd1, 2'd0), 0);
        check("cmp_c", flag_c, 0);

        // Shifts and self-referencing ADD.
        run(ldi(2'd0, 8'h81), 0);
        run(alu(4'h8, 2'd0, 2'd0, 2'd0), 0);
        check("shl_r0", bank[0], 16'h02);
        run(alu(4'h9, 2'd0, 2'd0, 2'd0), 0);
        check("shr_r0", bank[0], 16'h01);
        run(ldi(2'd1, 8'h40), 0);
        run(alu(4'h3, 2'd1, 2'd1, 2'd1), 0);
        check("dbl_r1", bank[1], 16'h80);

        // OUT with back-pressure, NOP, illegal then LDI.
        run(ldi(2'd2, 8'h3C), 0);
        run(alu(4'hB, 2'd0, 2'd2, 2'd0), 5);
        run(16'h0000, 0);
        run(alu(4'hE, 2'd1, 2'd0, 2'd0), 0);
        check("err_set", err, 1);
        run(ldi(2'd3, 8'h99), 0);
        check("err_sticky", err, 1);

        // Reset asserted during EXEC of an ADD.
        @(negedge clk);
        instr = alu(4'h3, 2'd2, 2'd3, 2'd3);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        for (k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_wr_n", wr_n, 1);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_vals("post");
        run(ldi(2'd1, 8'h01), 0);

        // Random instructions, mostly legal.
        for (int n = 0; n < 300; n++) begin
            ins = 16'($urandom);
            op = $urandom_range(0, 15);
            if (op >= 12 && $urandom_range(0, 7) != 0) op = $urandom_range(1, 11);
            ins[15:12] = 4'(op);
            run(ins, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
